rgb_white_balance: RTL

- Sits directly downstream of the bilinear demosaicing stage and consumes its RGB AXI4-Stream.
- Applies a per-channel unsigned fixed-point gain with rounding and saturation. Gains are frame-coherent: they are latched at frame start.
- Also accumulates per-frame, pre-gain channel sums and the pixel count, for auto-white-balance firmware.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/axi4_stream_if.sv | 28 ++
 rtl/wb_channel_mul.sv | 34 +++
 rtl/rgb_white_balance.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and fixed-point helpers for the RGB white-balance block.
package wb_pkg;

  localparam int unsigned PX_WIDTH_DEF   = 10;
  localparam int unsigned GAIN_WIDTH_DEF = 12;
  localparam int unsigned GAIN_FRAC_DEF  = 8;
  localparam int unsigned STAT_WIDTH_DEF = 32;

  localparam int unsigned GAIN_ONE = 1 << GAIN_FRAC_DEF;

  // Component field indices inside the packed TDATA word.
  localparam int unsigned G = 0;
  localparam int unsigned B = 1;
  localparam int unsigned R = 2;

  // Round-half-up the fixed-point product, then clamp to the pixel range.
  function automatic logic [31:0] sat_round(input logic [63:0] product,
                                            input int unsigned frac = GAIN_FRAC_DEF,
                                            input int unsigned px_w = PX_WIDTH_DEF);
    logic [63:0] rounded;
    logic [63:0] max_v;
    rounded = (product + (64'd1 << (frac - 1))) >> frac;
    max_v   = (64'd1 << px_w) - 64'd1;
    return (rounded > max_v) ? max_v[31:0] : rounded[31:0];
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views; tuser marks start of frame.
interface axi4_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1
);

    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic                    tlast;
    logic                    tuser;
    logic [ID_WIDTH-1:0]     tid;
    logic [DEST_WIDTH-1:0]   tdest;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
        output tready
    );

endinterface

// File: rtl/wb_channel_mul.sv
// One colour channel: stage-1 multiply, stage-2 round and saturate, shared stall enable.
module wb_channel_mul
    import wb_pkg::*;
#(
    parameter int unsigned PX_WIDTH   = PX_WIDTH_DEF,
    parameter int unsigned GAIN_WIDTH = GAIN_WIDTH_DEF,
    parameter int unsigned GAIN_FRAC  = GAIN_FRAC_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PX_WIDTH-1:0]   comp_i,
    input  logic [GAIN_WIDTH-1:0] gain_i,
    output logic [PX_WIDTH-1:0]   comp_o
);

    localparam int unsigned PROD_WIDTH = PX_WIDTH + GAIN_WIDTH;

    logic [PROD_WIDTH-1:0] prod_q;
    logic [PX_WIDTH-1:0]   rounded;

    assign rounded = PX_WIDTH'(sat_round(64'(prod_q), GAIN_FRAC, PX_WIDTH));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
            comp_o <= '0;
        end else if (en_i) begin
            prod_q <= PROD_WIDTH'(comp_i) * PROD_WIDTH'(gain_i);
            comp_o <= rounded;
        end
    end

endmodule

// File: rtl/rgb_white_balance.sv
// Frame-coherent per-channel white-balance gain on an RGB stream, plus per-frame
// pre-gain channel sums and pixel count for auto-white-balance firmware.
module rgb_white_balance
    import wb_pkg::*;
#(
    parameter int unsigned PX_WIDTH   = PX_WIDTH_DEF,
    parameter int unsigned GAIN_WIDTH = GAIN_WIDTH_DEF,
    parameter int unsigned GAIN_FRAC  = GAIN_FRAC_DEF,
    parameter int unsigned STAT_WIDTH = STAT_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_en_i,
    input  logic [GAIN_WIDTH-1:0] r_gain_i,
    input  logic [GAIN_WIDTH-1:0] g_gain_i,
    input  logic [GAIN_WIDTH-1:0] b_gain_i,
    axi4_stream_if.slave          rgb_video_i,
    axi4_stream_if.master         rgb_video_o,
    output logic [STAT_WIDTH-1:0] r_sum_o,
    output logic [STAT_WIDTH-1:0] g_sum_o,
    output logic [STAT_WIDTH-1:0] b_sum_o,
    output logic [STAT_WIDTH-1:0] px_cnt_o,
    output logic                  stats_valid_o
);

    localparam int unsigned DATA_WIDTH = ((3 * PX_WIDTH + 7) / 8) * 8;

    logic                           adv;
    logic                           accept;
    logic [2:0][PX_WIDTH-1:0]       comp_in;
    logic [2:0][PX_WIDTH-1:0]       comp_out;
    logic [2:0][GAIN_WIDTH-1:0]     gain_new;
    logic [2:0][GAIN_WIDTH-1:0]     gain_eff;
    logic                           en_sel;
    logic [2:0][GAIN_WIDTH-1:0]     gain_sel;

    logic                           sh_en_q;
    logic [2:0][GAIN_WIDTH-1:0]     sh_gain_q;
    logic [1:0]                     vld_q;
    logic [1:0]                     last_q;
    logic [1:0]                     user_q;

    logic [2:0][STAT_WIDTH-1:0]     acc_q;
    logic [STAT_WIDTH-1:0]          cnt_q;
    logic                           in_frame_q;
    logic [2:0][STAT_WIDTH-1:0]     sum_q;
    logic [STAT_WIDTH-1:0]          px_q;
    logic                           pulse_q;

    function automatic logic [STAT_WIDTH-1:0] sat_add(input logic [STAT_WIDTH-1:0] a,
                                                      input logic [STAT_WIDTH-1:0] b);
        logic [STAT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_WIDTH] ? '1 : s[STAT_WIDTH-1:0];
    endfunction

    assign adv                = !vld_q[1] || rgb_video_o.tready;
    assign rgb_video_i.tready = adv;
    assign accept             = rgb_video_i.tvalid && adv;
    assign comp_in            = rgb_video_i.tdata[3*PX_WIDTH-1:0];
    assign gain_new           = {r_gain_i, b_gain_i, g_gain_i};

    // A start-of-frame beat already sees the gains it is about to latch; bypass
    // is a unity gain, which round-trips every component exactly.
    always_comb begin
        en_sel   = rgb_video_i.tuser ? wb_en_i : sh_en_q;
        gain_sel = rgb_video_i.tuser ? gain_new : sh_gain_q;
        gain_eff = '0;
        for (int i = 0; i < 3; i++) begin
            gain_eff[i] = en_sel ? gain_sel[i] : GAIN_WIDTH'(GAIN_ONE);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        wb_channel_mul #(
            .PX_WIDTH  (PX_WIDTH),
            .GAIN_WIDTH(GAIN_WIDTH),
            .GAIN_FRAC (GAIN_FRAC)
        ) u_ch (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (adv),
            .comp_i(comp_in[i]),
            .gain_i(gain_eff[i]),
            .comp_o(comp_out[i])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_en_q   <= 1'b0;
            sh_gain_q <= {3{GAIN_WIDTH'(GAIN_ONE)}};
            vld_q     <= '0;
            last_q    <= '0;
            user_q    <= '0;
        end else begin
            if (accept && rgb_video_i.tuser) begin
                sh_en_q   <= wb_en_i;
                sh_gain_q <= gain_new;
            end
            if (adv) begin
                vld_q  <= {vld_q[0], rgb_video_i.tvalid};
                last_q <= {last_q[0], rgb_video_i.tlast};
                user_q <= {user_q[0], rgb_video_i.tuser};
            end
        end
    end

    assign rgb_video_o.tvalid = vld_q[1];
    assign rgb_video_o.tlast  = last_q[1];
    assign rgb_video_o.tuser  = user_q[1];
    assign rgb_video_o.tdata  = DATA_WIDTH'(comp_out);
    assign rgb_video_o.tkeep  = '1;
    assign rgb_video_o.tstrb  = '1;
    assign rgb_video_o.tid    = '0;
    assign rgb_video_o.tdest  = '0;

    // Beats before the first frame start after reset belong to a discarded frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            in_frame_q <= 1'b0;
            sum_q      <= '0;
            px_q       <= '0;
            pulse_q    <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (accept) begin
                if (rgb_video_i.tuser) begin
                    in_frame_q <= 1'b1;
                    if (cnt_q != '0) begin
                        sum_q   <= acc_q;
                        px_q    <= cnt_q;
                        pulse_q <= 1'b1;
                    end
                    for (int i = 0; i < 3; i++) begin
                        acc_q[i] <= STAT_WIDTH'(comp_in[i]);
                    end
                    cnt_q <= STAT_WIDTH'(1);
                end else if (in_frame_q) begin
                    for (int i = 0; i < 3; i++) begin
                        acc_q[i] <= sat_add(acc_q[i], STAT_WIDTH'(comp_in[i]));
                    end
                    cnt_q <= sat_add(cnt_q, STAT_WIDTH'(1));
                end
            end
        end
    end

    assign r_sum_o       = sum_q[R];
    assign g_sum_o       = sum_q[G];
    assign b_sum_o       = sum_q[B];
    assign px_cnt_o      = px_q;
    assign stats_valid_o = pulse_q;

endmodule
